// File: rtl/syndrome_accumulator_if.sv
// Configuration package and the input stream interface (rotated vectors from
// the cyclic shift network into the syndrome accumulator).
package configs;
   parameter int LiftingFactor = 8;
endpackage

interface syndrome_accumulator_if #(
   parameter int LiftingFactor = configs::LiftingFactor
);
   logic in_valid;
   logic in_ready;
   logic in_last;
   logic in_data [LiftingFactor];

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/syndrome_accumulator.sv
// XOR-accumulates rotated circulant vectors per block row, reports each row
// syndrome, and flags a codeword pass when every row syndrome is zero.
module syndrome_accumulator #(
   parameter int LiftingFactor = configs::LiftingFactor,
   parameter int NumRows       = 2,
   parameter int NumCols       = 4,
   localparam int RowW         = (NumRows > 1) ? $clog2(NumRows) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   syndrome_accumulator_if.slave in_bus,
   output logic                row_syndrome [LiftingFactor],
   output logic                row_valid,
   output logic [RowW-1:0]     row_idx,
   output logic                done,
   output logic                pass,
   output logic                err
);

   localparam int ColW = (NumCols > 1) ? $clog2(NumCols) : 1;
   localparam logic [ColW-1:0] LastCol = ColW'(NumCols - 1);
   localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      ROW_OUT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                   state_r, state_s;
   logic [LiftingFactor-1:0] acc_r, acc_s;
   logic [LiftingFactor-1:0] data_s;
   logic [LiftingFactor-1:0] row_syn_r, row_syn_s;
   logic [ColW-1:0]          col_r, col_s;
   logic [RowW-1:0]          row_r, row_s;
   logic                     fail_r, fail_s;
   logic                     err_r, err_s;
   logic                     ready_r, row_valid_r, done_r, pass_r;
   logic                     hs_s;

   function automatic logic any_set(input logic [LiftingFactor-1:0] v);
      return |v;
   endfunction

   for (genvar i = 0; i < LiftingFactor; i++) begin : g_bits
      assign data_s[i]       = in_bus.in_data[i];
      assign row_syndrome[i] = row_syn_r[i];
   end

   assign hs_s            = in_bus.in_valid & ready_r;
   assign in_bus.in_ready = ready_r;
   assign row_valid       = row_valid_r;
   assign row_idx         = row_r;
   assign done            = done_r;
   assign pass            = pass_r;
   assign err             = err_r;

   // Next-state and datapath update for the accumulate/report sequence.
   always_comb begin
      state_s   = state_r;
      acc_s     = acc_r;
      col_s     = col_r;
      row_s     = row_r;
      fail_s    = fail_r;
      err_s     = err_r;
      row_syn_s = row_syn_r;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               state_s = ACCUM;
               acc_s   = {LiftingFactor{1'b0}};
               col_s   = {ColW{1'b0}};
               row_s   = {RowW{1'b0}};
               fail_s  = 1'b0;
               err_s   = 1'b0;
            end else begin
               state_s = state_r;
            end
         end
         ACCUM: begin
            if (hs_s) begin
               acc_s = acc_r ^ data_s;
               col_s = col_r + 1'b1;
               // in_last must coincide exactly with the final column of the row
               if (in_bus.in_last != (col_r == LastCol)) begin
                  err_s = 1'b1;
               end else begin
                  err_s = err_r;
               end
               if (in_bus.in_last) begin
                  state_s   = ROW_OUT;
                  row_syn_s = acc_r ^ data_s;
               end else begin
                  state_s = ACCUM;
               end
            end else begin
               state_s = ACCUM;
            end
         end
         ROW_OUT: begin
            if (any_set(acc_r)) begin
               fail_s = 1'b1;
            end else begin
               fail_s = fail_r;
            end
            if (row_r == LastRow) begin
               state_s = DONE;
            end else begin
               state_s = ACCUM;
               acc_s   = {LiftingFactor{1'b0}};
               col_s   = {ColW{1'b0}};
               row_s   = row_r + 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs (outputs decoded from next state).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         acc_r       <= {LiftingFactor{1'b0}};
         col_r       <= {ColW{1'b0}};
         row_r       <= {RowW{1'b0}};
         fail_r      <= 1'b0;
         err_r       <= 1'b0;
         row_syn_r   <= {LiftingFactor{1'b0}};
         ready_r     <= 1'b0;
         row_valid_r <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         acc_r       <= acc_s;
         col_r       <= col_s;
         row_r       <= row_s;
         fail_r      <= fail_s;
         err_r       <= err_s;
         row_syn_r   <= row_syn_s;
         ready_r     <= (state_s == ACCUM);
         row_valid_r <= (state_s == ROW_OUT);
         done_r      <= (state_s == DONE);
         pass_r      <= (state_s == DONE) & ~fail_s & ~err_s;
      end
   end

endmodule

// File: tb/tb_syndrome_accumulator.sv
// Directed self-checking bench for syndrome_accumulator (L=4, 2 rows, 2 cols).
module tb_syndrome_accumulator;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       row_syndrome [4];
   logic       row_valid;
   logic [0:0] row_idx;
   logic       done;
   logic       pass;
   logic       err;
   int         checks;
   int         failures;

   syndrome_accumulator_if #(.LiftingFactor(4)) bus ();

   syndrome_accumulator #(
      .LiftingFactor(4),
      .NumRows(2),
      .NumCols(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .in_bus(bus.slave),
      .row_syndrome(row_syndrome),
      .row_valid(row_valid),
      .row_idx(row_idx),
      .done(done),
      .pass(pass),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] syn();
      logic [3:0] s;
      for (int i = 0; i < 4; i++) s[i] = row_syndrome[i];
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one beat after 'gap' idle cycles; returns 1 ns after the handshake edge.
   task automatic beat(input logic [3:0] d, input logic l, input int gap);
      int k;
      bus.in_valid = 1'b0;
      repeat (gap) tick();
      bus.in_valid = 1'b1;
      bus.in_last  = l;
      for (int i = 0; i < 4; i++) bus.in_data[i] = d[i];
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      checks++;
      if (k >= 20) begin
         failures++;
         $display("FAIL beat_timeout in_ready=%b required 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.in_ready); end
      checks++; if (row_valid !== 1'b0) begin failures++; $display("FAIL rst_row_valid got=%b exp=0", row_valid); end
      checks++; if (done !== 1'b0 || pass !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_flags got done=%b pass=%b err=%b exp 0 0 0", done, pass, err); end
      checks++; if (row_idx !== 1'b0 || syn() !== 4'b0000) begin failures++; $display("FAIL rst_row got idx=%b syn=%b exp 0 0000", row_idx, syn()); end
      #21 rst_n = 1'b1;
      tick(); tick(); tick();
      checks++; if (bus.in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_wait got ready=%b done=%b exp 0 0", bus.in_ready, done); end
   endtask

   // Clean codeword: rows {1010,1010} and {0110,0110}, both syndromes zero.
   task automatic test_clean(input int gap, input string tag);
      do_start();
      checks++; if (bus.in_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL %s_accum got ready=%b done=%b exp 1 0", tag, bus.in_ready, done); end
      beat(4'b1010, 1'b0, gap);
      checks++; if (row_valid !== 1'b0) begin failures++; $display("FAIL %s_early_rv got=%b exp=0", tag, row_valid); end
      beat(4'b1010, 1'b1, gap);
      checks++; if (row_valid !== 1'b1 || syn() !== 4'b0000 || row_idx !== 1'b0) begin failures++; $display("FAIL %s_row0 got rv=%b syn=%b idx=%b exp 1 0000 0", tag, row_valid, syn(), row_idx); end
      tick();
      checks++; if (row_valid !== 1'b0) begin failures++; $display("FAIL %s_row0_pulse got=%b exp=0", tag, row_valid); end
      beat(4'b0110, 1'b0, gap);
      beat(4'b0110, 1'b1, gap);
      checks++; if (row_valid !== 1'b1 || syn() !== 4'b0000 || row_idx !== 1'b1) begin failures++; $display("FAIL %s_row1 got rv=%b syn=%b idx=%b exp 1 0000 1", tag, row_valid, syn(), row_idx); end
      checks++; if (done !== 1'b0 || pass !== 1'b0) begin failures++; $display("FAIL %s_not_done got done=%b pass=%b exp 0 0", tag, done, pass); end
      tick();
      checks++; if (done !== 1'b1 || pass !== 1'b1 || err !== 1'b0 || row_valid !== 1'b0) begin failures++; $display("FAIL %s_done got done=%b pass=%b err=%b rv=%b exp 1 1 0 0", tag, done, pass, err, row_valid); end
   endtask

   task automatic test_nonzero_syndrome();
      do_start();
      beat(4'b1100, 1'b0, 0);
      beat(4'b0100, 1'b1, 0);
      checks++; if (row_valid !== 1'b1 || syn() !== 4'b1000 || row_idx !== 1'b0) begin failures++; $display("FAIL nz_row0 got rv=%b syn=%b idx=%b exp 1 1000 0", row_valid, syn(), row_idx); end
      beat(4'b0110, 1'b0, 2);
      checks++; if (syn() !== 4'b1000 || row_valid !== 1'b0) begin failures++; $display("FAIL nz_hold got syn=%b rv=%b exp 1000 0", syn(), row_valid); end
      beat(4'b0110, 1'b1, 0);
      checks++; if (syn() !== 4'b0000 || row_idx !== 1'b1) begin failures++; $display("FAIL nz_row1 got syn=%b idx=%b exp 0000 1", syn(), row_idx); end
      tick();
      checks++; if (done !== 1'b1 || pass !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL nz_done got done=%b pass=%b err=%b exp 1 0 0", done, pass, err); end
   endtask

   task automatic test_protocol_error();
      do_start();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL perr_clear got=%b exp=0", err); end
      beat(4'b0000, 1'b1, 0);
      checks++; if (row_valid !== 1'b1 || err !== 1'b1 || syn() !== 4'b0000) begin failures++; $display("FAIL perr_row0 got rv=%b err=%b syn=%b exp 1 1 0000", row_valid, err, syn()); end
      beat(4'b0000, 1'b0, 0);
      beat(4'b0000, 1'b1, 0);
      checks++; if (err !== 1'b1 || row_idx !== 1'b1) begin failures++; $display("FAIL perr_sticky got err=%b idx=%b exp 1 1", err, row_idx); end
      tick();
      checks++; if (done !== 1'b1 || pass !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL perr_done got done=%b pass=%b err=%b exp 1 0 1", done, pass, err); end
   endtask

   task automatic test_reset_mid();
      do_start();
      beat(4'b1010, 1'b0, 0);
      beat(4'b1010, 1'b1, 0);
      tick();
      beat(4'b0110, 1'b0, 0);
      rst_n = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b0 || row_valid !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err !== 1'b0 || row_idx !== 1'b0 || syn() !== 4'b0000) begin failures++; $display("FAIL midrst_outputs got ready=%b rv=%b done=%b pass=%b err=%b idx=%b syn=%b exp all 0", bus.in_ready, row_valid, done, pass, err, row_idx, syn()); end
      #12 rst_n = 1'b1;
      tick(); tick();
      checks++; if (row_valid !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_idle got rv=%b ready=%b exp 0 0", row_valid, bus.in_ready); end
      test_clean(0, "after_rst");
   endtask

   task automatic test_start_ignored();
      do_start();
      beat(4'b1010, 1'b0, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (bus.in_ready !== 1'b1 || row_idx !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL start_accum got ready=%b idx=%b done=%b exp 1 0 0", bus.in_ready, row_idx, done); end
      beat(4'b1010, 1'b1, 0);
      checks++; if (row_valid !== 1'b1 || syn() !== 4'b0000 || err !== 1'b0) begin failures++; $display("FAIL start_row0 got rv=%b syn=%b err=%b exp 1 0000 0", row_valid, syn(), err); end
      tick();
      beat(4'b0110, 1'b0, 0);
      beat(4'b0110, 1'b1, 0);
      tick();
      checks++; if (done !== 1'b1 || pass !== 1'b1) begin failures++; $display("FAIL start_done got done=%b pass=%b exp 1 1", done, pass); end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (done !== 1'b0 || pass !== 1'b0 || bus.in_ready !== 1'b1 || row_idx !== 1'b0) begin failures++; $display("FAIL restart got done=%b pass=%b ready=%b idx=%b exp 0 0 1 0", done, pass, bus.in_ready, row_idx); end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      for (int i = 0; i < 4; i++) bus.in_data[i] = 1'b0;
      test_reset();
      test_clean(0, "clean");
      test_nonzero_syndrome();
      test_protocol_error();
      test_clean(3, "stall");
      test_reset_mid();
      test_start_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/syndrome_accumulator.md
SYNDROME_ACCUMULATOR -- requirements
Module: syndrome_accumulator

Interface
REQ-001 SHALL have parameter LiftingFactor, default configs::LiftingFactor, meaning the circulant size (bits per vector).
REQ-002 SHALL have parameter NumRows, default 2, meaning the block rows per codeword (>=1).
REQ-003 SHALL have parameter NumCols, default 4, meaning the non-zero circulants per block row (>=1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: begin a codeword syndrome check.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts in_data.
REQ-009 SHALL have port in_data, input, unpacked array [LiftingFactor] of 1 bit: the rotated vector from the cyclic shift network.
REQ-010 SHALL have port in_last, input, 1 bit: marks the last circulant of the current block row.
REQ-011 SHALL have port row_syndrome, output, unpacked array [LiftingFactor] of 1 bit: the finished block-row syndrome.
REQ-012 SHALL have port row_valid, output, 1 bit: one-cycle strobe qualifying row_syndrome and row_idx.
REQ-013 SHALL have port row_idx, output, $clog2(NumRows) bits (min 1): the index of the reported block row.
REQ-014 SHALL have port done, output, 1 bit: the codeword check is complete.
REQ-015 SHALL have port pass, output, 1 bit: all syndromes are zero and there was no protocol error; valid while done=1.
REQ-016 SHALL have port err, output, 1 bit: sticky protocol error for the current codeword.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCUM, ROW_OUT and DONE.
REQ-018 In IDLE, start=1 SHALL go to ACCUM, clearing the accumulator, the column count, row_idx, the fail flag and err.
REQ-019 SHALL drive in_ready=1 only in ACCUM; a handshake is in_valid & in_ready.
REQ-020 On each handshake, SHALL update acc <= acc ^ in_data bitwise and increment the column count.
REQ-021 SHALL set err if a handshake with in_last=1 occurs when the column count != NumCols-1, or a handshake with in_last=0 occurs when the column count == NumCols-1.
REQ-022 A handshake with in_last=1 SHALL move the FSM to ROW_OUT; the accumulator then holds the XOR including that beat.
REQ-023 In ROW_OUT, SHALL hold row_valid=1 for exactly one cycle, with row_syndrome = acc and the current row_idx; latency is 1 cycle after the last handshake.
REQ-024 In ROW_OUT, if any acc bit is 1, SHALL set the sticky fail flag.
REQ-025 From ROW_OUT, if row_idx == NumRows-1, SHALL go to DONE; otherwise SHALL go to ACCUM with acc cleared, the column count set to 0 and row_idx incremented.
REQ-026 In DONE, SHALL hold done=1 and pass = ~fail & ~err until start=1, which restarts exactly as from IDLE (REQ-018).
REQ-027 SHALL ignore start in ACCUM and ROW_OUT.
REQ-028 SHALL hold row_syndrome stable outside row_valid, at its last reported value.
REQ-029 SHALL keep pass=0 whenever done=0.
REQ-030 in_valid with no handshake SHALL leave all state unchanged; stalls of any length are permitted.

Reset
REQ-031 rst_n=0 SHALL asynchronously force the FSM to IDLE and drive in_ready=0, row_valid=0, done=0, pass=0, err=0, row_idx=0, row_syndrome all 0 and acc all 0.
REQ-032 Reset mid-codeword SHALL discard all partial state; no row_valid SHALL be issued for the aborted row.
REQ-033 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification (bench: LiftingFactor=4, NumRows=2, NumCols=2)
REQ-034 Bench SHALL cover: start, then row 0 beats 1010, 1010(last) and row 1 beats 0110, 0110(last) -> two row_valid pulses with 0000, row_idx 0 then 1, then done=1, pass=1, err=0.
REQ-035 Bench SHALL cover: row 0 beats 1100, 0100(last) -> row_syndrome=1000 at row_idx 0; at the end done=1, pass=0.
REQ-036 Bench SHALL cover: in_last=1 on the first beat of row 0 -> err=1 sticky, row_valid is still issued, and at the end pass=0.
REQ-037 Bench SHALL cover: in_valid toggled randomly with 3-cycle gaps -> results identical to REQ-034, with row_valid exactly 1 cycle after each in_last handshake.
REQ-038 Bench SHALL cover: rst_n pulsed low after one beat of row 1 -> all outputs zero immediately; a new start then gives a clean result per REQ-034.
REQ-039 Bench SHALL cover: start asserted during ACCUM -> no effect; start asserted in DONE -> new check begins with done=0 the next cycle.
